// File: rtl/parking_pkg.sv
// Shared constants and types for the parking-garage elevator scheduler.
// Imported by the interface, the plate FIFO and the scheduler top.
package parking_pkg;

  localparam int QUEUE_DEPTH = 4;
  localparam int PLATE_W     = 16;
  localparam int COUNT_W     = 3;
  localparam int FLOOR_W     = 3;

  localparam logic DIR_PARK     = 1'b0;
  localparam logic DIR_RETRIEVE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/elevator_scheduler_if.sv
// Request/command bundle between the garage front end (master) and the scheduler (slave).
interface elevator_scheduler_if;
  import parking_pkg::*;

  logic               in_mode;
  logic               out_mode;
  logic [PLATE_W-1:0] license_plate;
  logic               leakage;
  logic [FLOOR_W-1:0] leakage_floor;
  logic               cmd_ready;
  logic               car_done;
  logic               cmd_valid;
  logic               cmd_dir;
  logic [PLATE_W-1:0] cmd_plate;
  logic [COUNT_W-1:0] in_count;
  logic [COUNT_W-1:0] out_count;
  logic               drop;
  logic               hold;
  logic [FLOOR_W-1:0] hold_floor;

  modport master (
    output in_mode, out_mode, license_plate, leakage, leakage_floor, cmd_ready, car_done,
    input  cmd_valid, cmd_dir, cmd_plate, in_count, out_count, drop, hold, hold_floor
  );

  modport slave (
    input  in_mode, out_mode, license_plate, leakage, leakage_floor, cmd_ready, car_done,
    output cmd_valid, cmd_dir, cmd_plate, in_count, out_count, drop, hold, hold_floor
  );

endinterface

// File: rtl/plate_fifo.sv
// Four-entry plate queue with a combinational "plate already queued" match on the push plate.
module plate_fifo
  import parking_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               push_i,
  input  logic [PLATE_W-1:0] pushPlate_i,
  input  logic               pop_i,
  output logic [PLATE_W-1:0] head_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               match_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  logic [PLATE_W-1:0]     slot_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] valid_q;
  logic [PTR_W-1:0]       rdPtr_q;
  logic [PTR_W-1:0]       wrPtr_q;
  logic [COUNT_W-1:0]     count_q;
  logic                   pushOk;
  logic                   popOk;

  assign pushOk  = push_i && (count_q != COUNT_W'(QUEUE_DEPTH));
  assign popOk   = pop_i && (count_q != '0);
  assign head_o  = slot_q[rdPtr_q];
  assign count_o = count_q;

  // Per-slot valid bits let the duplicate check ignore stale slot contents.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (pushOk) begin
        slot_q[wrPtr_q]  <= pushPlate_i;
        valid_q[wrPtr_q] <= 1'b1;
        wrPtr_q          <= wrPtr_q + PTR_W'(1);
      end
      if (popOk) begin
        valid_q[rdPtr_q] <= 1'b0;
        rdPtr_q          <= rdPtr_q + PTR_W'(1);
      end
      count_q <= count_q + COUNT_W'(pushOk) - COUNT_W'(popOk);
    end
  end

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (valid_q[i] && (slot_q[i] == pushPlate_i)) match_o = 1'b1;
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// Scheduler top: filters park/retrieve requests into two plate queues and offers
// one elevator command at a time, round-robin between queues, pausing on leaks.
module elevator_scheduler
  import parking_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  elevator_scheduler_if.slave  bus
);

  logic [PLATE_W-1:0] inHead;
  logic [PLATE_W-1:0] outHead;
  logic [COUNT_W-1:0] inCount;
  logic [COUNT_W-1:0] outCount;
  logic               inMatch;
  logic               outMatch;
  logic               plateZero;
  logic               inAccept;
  logic               outAccept;
  logic               inReject;
  logic               outReject;
  logic               popIn;
  logic               popOut;
  logic               serveOut;

  state_e             state_q;
  logic               cmdValid_q;
  logic               cmdDir_q;
  logic [PLATE_W-1:0] cmdPlate_q;
  logic               drop_q;
  logic               hold_q;
  logic [FLOOR_W-1:0] holdFloor_q;
  logic               lastServed_q;

  // Full is judged on the pre-edge count, so a same-edge pop never rescues a push.
  assign plateZero = (bus.license_plate == '0);
  assign inAccept  = bus.in_mode  && !plateZero && !inMatch  && (inCount  != COUNT_W'(QUEUE_DEPTH));
  assign outAccept = bus.out_mode && !plateZero && !outMatch && (outCount != COUNT_W'(QUEUE_DEPTH));
  assign inReject  = bus.in_mode  && !inAccept;
  assign outReject = bus.out_mode && !outAccept;

  assign popIn    = (state_q == ST_OFFER) && bus.cmd_ready && (cmdDir_q == DIR_PARK);
  assign popOut   = (state_q == ST_OFFER) && bus.cmd_ready && (cmdDir_q == DIR_RETRIEVE);
  assign serveOut = (outCount != '0) && ((inCount == '0) || (lastServed_q == DIR_PARK));

  plate_fifo u_inFifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (inAccept),
    .pushPlate_i (bus.license_plate),
    .pop_i       (popIn),
    .head_o      (inHead),
    .count_o     (inCount),
    .match_o     (inMatch)
  );

  plate_fifo u_outFifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (outAccept),
    .pushPlate_i (bus.license_plate),
    .pop_i       (popOut),
    .head_o      (outHead),
    .count_o     (outCount),
    .match_o     (outMatch)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cmdValid_q   <= 1'b0;
      cmdDir_q     <= DIR_PARK;
      cmdPlate_q   <= '0;
      drop_q       <= 1'b0;
      hold_q       <= 1'b0;
      holdFloor_q  <= '0;
      lastServed_q <= DIR_PARK;
    end else begin
      drop_q <= inReject || outReject;
      if (bus.leakage) holdFloor_q <= bus.leakage_floor;
      case (state_q)
        ST_IDLE: begin
          if (bus.leakage) begin
            state_q <= ST_HOLD;
            hold_q  <= 1'b1;
          end else if ((inCount != '0) || (outCount != '0)) begin
            state_q    <= ST_OFFER;
            cmdValid_q <= 1'b1;
            cmdDir_q   <= serveOut ? DIR_RETRIEVE : DIR_PARK;
            cmdPlate_q <= serveOut ? outHead : inHead;
          end
        end
        // Leakage cannot withdraw a command already on offer.
        ST_OFFER: begin
          if (bus.cmd_ready) begin
            state_q      <= ST_BUSY;
            cmdValid_q   <= 1'b0;
            lastServed_q <= cmdDir_q;
          end
        end
        ST_BUSY: begin
          if (bus.car_done) begin
            state_q <= bus.leakage ? ST_HOLD : ST_IDLE;
            hold_q  <= bus.leakage;
          end
        end
        ST_HOLD: begin
          if (!bus.leakage) begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          cmdValid_q <= 1'b0;
          hold_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_valid  = cmdValid_q;
  assign bus.cmd_dir    = cmdDir_q;
  assign bus.cmd_plate  = cmdPlate_q;
  assign bus.in_count   = inCount;
  assign bus.out_count  = outCount;
  assign bus.drop       = drop_q;
  assign bus.hold       = hold_q;
  assign bus.hold_floor = holdFloor_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: directed scenarios plus a random run
// compared every cycle against a queue-based reference model.
module tb_elevator_scheduler;
  import parking_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;

  elevator_scheduler_if bus();

  elevator_scheduler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDLE, M_OFFER, M_BUSY, M_HOLD} mstate_e;

  logic [15:0] inQ[$];
  logic [15:0] outQ[$];
  mstate_e     mState = M_IDLE;
  logic        mValid = 1'b0;
  logic        mDir = 1'b0;
  logic [15:0] mPlate = '0;
  logic        mDrop = 1'b0;
  logic        mHold = 1'b0;
  logic [2:0]  mFloor = '0;
  logic        mLastOut = 1'b0;

  function automatic bit qHas(input logic [15:0] q[$], input logic [15:0] p);
    foreach (q[i]) if (q[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  // Reference behaviour for one rising edge, using the inputs as seen at that edge.
  task automatic model_edge();
    bit inAcc, outAcc, useOut;
    logic [15:0] p;
    p = bus.license_plate;
    if (!reset) begin
      inQ.delete(); outQ.delete();
      mState = M_IDLE; mValid = 0; mDir = 0; mPlate = '0;
      mDrop = 0; mHold = 0; mFloor = '0; mLastOut = 0;
      return;
    end
    inAcc  = bus.in_mode  && inQ.size()  < 4 && p != 16'h0 && !qHas(inQ, p);
    outAcc = bus.out_mode && outQ.size() < 4 && p != 16'h0 && !qHas(outQ, p);
    mDrop  = (bus.in_mode && !inAcc) || (bus.out_mode && !outAcc);
    if (bus.leakage) mFloor = bus.leakage_floor;
    case (mState)
      M_IDLE: begin
        if (bus.leakage) mState = M_HOLD;
        else if (inQ.size() != 0 || outQ.size() != 0) begin
          useOut = outQ.size() != 0 && (inQ.size() == 0 || !mLastOut);
          mDir   = useOut;
          mPlate = useOut ? outQ[0] : inQ[0];
          mState = M_OFFER;
        end
      end
      M_OFFER: if (bus.cmd_ready) begin
        if (mDir) void'(outQ.pop_front()); else void'(inQ.pop_front());
        mLastOut = mDir;
        mState   = M_BUSY;
      end
      M_BUSY: if (bus.car_done) mState = bus.leakage ? M_HOLD : M_IDLE;
      M_HOLD: if (!bus.leakage) mState = M_IDLE;
      default: mState = M_IDLE;
    endcase
    if (inAcc)  inQ.push_back(p);
    if (outAcc) outQ.push_back(p);
    mValid = (mState == M_OFFER);
    mHold  = (mState == M_HOLD);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic drive_idle();
    bus.in_mode = 0; bus.out_mode = 0; bus.license_plate = '0;
    bus.leakage = 0; bus.leakage_floor = '0; bus.cmd_ready = 0; bus.car_done = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic park(input logic [15:0] p);
    bus.in_mode = 1; bus.license_plate = p;
    tick();
    bus.in_mode = 0; bus.license_plate = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", bus.cmd_valid); end
    checks++; if (bus.cmd_plate !== 16'h0) begin errors++; $display("[TB] FAIL reset_plate got %h want 0000", bus.cmd_plate); end
    checks++; if (bus.cmd_dir !== 1'b0) begin errors++; $display("[TB] FAIL reset_dir got %b want 0", bus.cmd_dir); end
    checks++; if ({bus.in_count, bus.out_count} !== 6'd0) begin errors++; $display("[TB] FAIL reset_counts got %0d/%0d want 0/0", bus.in_count, bus.out_count); end
    checks++; if ({bus.drop, bus.hold, bus.hold_floor} !== 5'd0) begin errors++; $display("[TB] FAIL reset_flags got drop=%b hold=%b floor=%0d want 0", bus.drop, bus.hold, bus.hold_floor); end
  endtask

  task automatic test_single_park();
    do_reset();
    park(16'h9423);
    checks++; if (bus.in_count !== 3'd1) begin errors++; $display("[TB] FAIL park_count got %0d want 1", bus.in_count); end
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL park_early_valid got %b want 0", bus.cmd_valid); end
    tick();
    checks++; if ({bus.cmd_valid, bus.cmd_dir, bus.cmd_plate} !== {1'b1, 1'b0, 16'h9423}) begin errors++; $display("[TB] FAIL park_offer got v=%b d=%b p=%h want v=1 d=0 p=9423", bus.cmd_valid, bus.cmd_dir, bus.cmd_plate); end
    bus.cmd_ready = 1; tick(); bus.cmd_ready = 0;
    checks++; if ({bus.cmd_valid, bus.in_count} !== {1'b0, 3'd0}) begin errors++; $display("[TB] FAIL park_pop got v=%b cnt=%0d want v=0 cnt=0", bus.cmd_valid, bus.in_count); end
    bus.car_done = 1; tick(); bus.car_done = 0;
    park(16'h1357);
    tick();
    checks++; if ({bus.cmd_valid, bus.cmd_plate} !== {1'b1, 16'h1357}) begin errors++; $display("[TB] FAIL park_after_done got v=%b p=%h want v=1 p=1357", bus.cmd_valid, bus.cmd_plate); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.in_mode = 1; bus.out_mode = 1; bus.license_plate = 16'h1111;
    tick();
    drive_idle();
    checks++; if ({bus.in_count, bus.out_count} !== {3'd1, 3'd1}) begin errors++; $display("[TB] FAIL both_counts got %0d/%0d want 1/1", bus.in_count, bus.out_count); end
    tick();
    checks++; if ({bus.cmd_valid, bus.cmd_dir} !== 2'b11) begin errors++; $display("[TB] FAIL tie_out_first got v=%b d=%b want v=1 d=1", bus.cmd_valid, bus.cmd_dir); end
    bus.cmd_ready = 1; tick(); bus.cmd_ready = 0;
    checks++; if ({bus.in_count, bus.out_count} !== {3'd1, 3'd0}) begin errors++; $display("[TB] FAIL out_popped got %0d/%0d want 1/0", bus.in_count, bus.out_count); end
    bus.car_done = 1; tick(); bus.car_done = 0;
    tick();
    checks++; if ({bus.cmd_valid, bus.cmd_dir, bus.cmd_plate} !== {1'b1, 1'b0, 16'h1111}) begin errors++; $display("[TB] FAIL in_second got v=%b d=%b p=%h want v=1 d=0 p=1111", bus.cmd_valid, bus.cmd_dir, bus.cmd_plate); end
  endtask

  task automatic test_full_and_reject();
    do_reset();
    park(16'h1001);
    checks++; if ({bus.drop, bus.in_count} !== {1'b0, 3'd1}) begin errors++; $display("[TB] FAIL first_accept got drop=%b cnt=%0d want 0/1", bus.drop, bus.in_count); end
    park(16'h1001);
    checks++; if ({bus.drop, bus.in_count} !== {1'b1, 3'd1}) begin errors++; $display("[TB] FAIL dup_reject got drop=%b cnt=%0d want 1/1", bus.drop, bus.in_count); end
    park(16'h0000);
    checks++; if ({bus.drop, bus.in_count} !== {1'b1, 3'd1}) begin errors++; $display("[TB] FAIL zero_reject got drop=%b cnt=%0d want 1/1", bus.drop, bus.in_count); end
    park(16'h1002); park(16'h1003); park(16'h1004);
    checks++; if ({bus.drop, bus.in_count} !== {1'b0, 3'd4}) begin errors++; $display("[TB] FAIL fill got drop=%b cnt=%0d want 0/4", bus.drop, bus.in_count); end
    park(16'h1005);
    checks++; if ({bus.drop, bus.in_count} !== {1'b1, 3'd4}) begin errors++; $display("[TB] FAIL full_reject got drop=%b cnt=%0d want 1/4", bus.drop, bus.in_count); end
    tick();
    checks++; if ({bus.drop, bus.cmd_valid, bus.cmd_plate} !== {1'b0, 1'b1, 16'h1001}) begin errors++; $display("[TB] FAIL drop_pulse got drop=%b v=%b p=%h want 0/1/1001", bus.drop, bus.cmd_valid, bus.cmd_plate); end
    bus.cmd_ready = 1; park(16'h1006); bus.cmd_ready = 0;
    checks++; if ({bus.drop, bus.in_count} !== {1'b1, 3'd3}) begin errors++; $display("[TB] FAIL full_pop_same_edge got drop=%b cnt=%0d want 1/3", bus.drop, bus.in_count); end
  endtask

  task automatic test_leak_busy();
    do_reset();
    park(16'h2222);
    tick();
    bus.cmd_ready = 1; tick(); bus.cmd_ready = 0;
    park(16'h3333);
    bus.leakage = 1; bus.leakage_floor = 3'd1;
    tick();
    checks++; if ({bus.hold, bus.hold_floor} !== {1'b0, 3'd1}) begin errors++; $display("[TB] FAIL leak_in_busy got hold=%b floor=%0d want 0/1", bus.hold, bus.hold_floor); end
    bus.car_done = 1; tick(); bus.car_done = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus.hold, bus.cmd_valid, bus.hold_floor} !== {1'b1, 1'b0, 3'd1}) begin errors++; $display("[TB] FAIL hold_state got hold=%b v=%b floor=%0d want 1/0/1", bus.hold, bus.cmd_valid, bus.hold_floor); end
      tick();
    end
    bus.leakage = 0;
    tick();
    checks++; if ({bus.hold, bus.cmd_valid} !== 2'b00) begin errors++; $display("[TB] FAIL hold_exit got hold=%b v=%b want 0/0", bus.hold, bus.cmd_valid); end
    tick();
    checks++; if ({bus.cmd_valid, bus.cmd_plate, bus.hold_floor} !== {1'b1, 16'h3333, 3'd1}) begin errors++; $display("[TB] FAIL after_hold_offer got v=%b p=%h floor=%0d want 1/3333/1", bus.cmd_valid, bus.cmd_plate, bus.hold_floor); end
  endtask

  task automatic test_leak_offer();
    do_reset();
    park(16'h4444);
    tick();
    bus.leakage = 1; bus.leakage_floor = 3'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({bus.cmd_valid, bus.cmd_plate, bus.hold} !== {1'b1, 16'h4444, 1'b0}) begin errors++; $display("[TB] FAIL offer_stable got v=%b p=%h hold=%b want 1/4444/0", bus.cmd_valid, bus.cmd_plate, bus.hold); end
    end
    bus.cmd_ready = 1; tick(); bus.cmd_ready = 0;
    checks++; if (bus.cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL offer_taken got %b want 0", bus.cmd_valid); end
    bus.car_done = 1; tick(); bus.car_done = 0;
    checks++; if ({bus.hold, bus.hold_floor} !== {1'b1, 3'd5}) begin errors++; $display("[TB] FAIL done_to_hold got hold=%b floor=%0d want 1/5", bus.hold, bus.hold_floor); end
    bus.leakage = 0; tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    park(16'h5001);
    bus.out_mode = 1; park(16'h5002); bus.out_mode = 0;
    park(16'h5003);
    checks++; if ({bus.cmd_valid, bus.in_count, bus.out_count} !== {1'b1, 3'd3, 3'd1}) begin errors++; $display("[TB] FAIL pre_reset got v=%b cnt=%0d/%0d want 1/3/1", bus.cmd_valid, bus.in_count, bus.out_count); end
    reset = 0; bus.in_mode = 1; bus.license_plate = 16'h5004;
    tick();
    checks++; if ({bus.cmd_valid, bus.in_count, bus.out_count, bus.cmd_plate} !== {1'b0, 3'd0, 3'd0, 16'h0}) begin errors++; $display("[TB] FAIL mid_reset got v=%b cnt=%0d/%0d p=%h want 0/0/0/0000", bus.cmd_valid, bus.in_count, bus.out_count, bus.cmd_plate); end
    reset = 1; drive_idle();
    tick();
    checks++; if ({bus.cmd_valid, bus.in_count} !== {1'b0, 3'd0}) begin errors++; $display("[TB] FAIL reset_req_ignored got v=%b cnt=%0d want 0/0", bus.cmd_valid, bus.in_count); end
  endtask

  task automatic test_random();
    logic [15:0] plates [6];
    logic [28:0] got, want;
    plates[0] = 16'h0000; plates[1] = 16'h1234; plates[2] = 16'h2345;
    plates[3] = 16'h3456; plates[4] = 16'h4567; plates[5] = 16'h9999;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset             = ($urandom_range(0, 199) != 0);
      bus.in_mode       = ($urandom_range(0, 9) < 4);
      bus.out_mode      = ($urandom_range(0, 9) < 3);
      bus.license_plate = plates[$urandom_range(0, 5)];
      if ($urandom_range(0, 19) == 0) bus.leakage = ~bus.leakage;
      bus.leakage_floor = 3'($urandom_range(0, 7));
      bus.cmd_ready     = ($urandom_range(0, 2) == 0);
      bus.car_done      = ($urandom_range(0, 3) == 0);
      tick();
      got  = {bus.cmd_valid, bus.cmd_dir, bus.cmd_plate, bus.in_count, bus.out_count, bus.drop, bus.hold, bus.hold_floor};
      want = {mValid, mDir, mPlate, 3'(inQ.size()), 3'(outQ.size()), mDrop, mHold, mFloor};
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL random_cycle_%0d got v=%b d=%b p=%h in=%0d out=%0d drop=%b hold=%b fl=%0d want v=%b d=%b p=%h in=%0d out=%0d drop=%b hold=%b fl=%0d",
                 cyc, got[28], got[27], got[26:11], got[10:8], got[7:5], got[4], got[3], got[2:0],
                 want[28], want[27], want[26:11], want[10:8], want[7:5], want[4], want[3], want[2:0]);
      end
    end
    reset = 1;
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single_park();
    test_simultaneous();
    test_full_and_reject();
    test_leak_busy();
    test_leak_offer();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
